// File: rtl/lane_trace_capture.sv
// ============================================================================
// lane_trace_capture: timestamps RX/TX lane payloads into records and buffers
// them in a show-ahead FIFO drained over a ready/valid port.
// Revision: 1.0
// ============================================================================
`default_nettype none

module lane_trace_capture #(
  parameter int LANS     = 4,
  parameter int BYTES    = 2,
  parameter int DEPTH    = 16,
  parameter int TS_W     = 64,
  parameter int MODE_RST = 0,
  localparam int REC_W   = TS_W + 2*LANS*(9*BYTES+1),
  localparam int LVL_W   = $clog2(DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cap_en,
  input  logic [1:0]              mode,
  input  logic [LANS*BYTES*8-1:0] rdat,
  input  logic [LANS*BYTES-1:0]   rdatk,
  input  logic [LANS-1:0]         rdatv,
  input  logic [LANS*BYTES*8-1:0] tdat,
  input  logic [LANS*BYTES-1:0]   tdatk,
  input  logic [LANS-1:0]         tdatv,
  output logic [REC_W-1:0]        rec_data,
  output logic                    rec_valid,
  input  logic                    rec_ready,
  output logic [LVL_W-1:0]        level,
  output logic [15:0]             drop_cnt,
  output logic                    overflow
);

  localparam int c_p_w   = 2*LANS*(9*BYTES+1);
  localparam int c_ptr_w = $clog2(DEPTH);

  localparam logic [1:0] c_mode_valid  = 2'd1;
  localparam logic [1:0] c_mode_change = 2'd2;

  generate
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("lane_trace_capture: DEPTH must be a power of two >= 2");
    end
    if (MODE_RST < 0 || MODE_RST > 3) begin : g_bad_mode_rst
      $error("lane_trace_capture: MODE_RST must be in 0..3");
    end
  endgenerate

  logic [TS_W-1:0]    r_ts;
  logic               r_first;
  logic [c_p_w-1:0]   r_prev_p;
  logic [REC_W-1:0]   r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [LVL_W-1:0]   r_level;
  logic [15:0]        r_drop_cnt;
  logic               r_overflow;

  logic [c_p_w-1:0]   w_payload;
  logic               w_capture;
  logic               w_full;
  logic               w_pop;
  logic               w_push;
  logic               w_drop;

  assign w_payload = {rdatv, rdatk, rdat, tdatv, tdatk, tdat};

  // Mode is applied combinationally, so a new mode governs the very cycle it is sampled.
  always_comb begin
    w_capture = 1'b0;
    if (cap_en) begin
      case (mode)
        c_mode_valid:  w_capture = (|rdatv) | (|tdatv);
        c_mode_change: w_capture = r_first | (w_payload != r_prev_p);
        default:       w_capture = 1'b1;
      endcase
    end
  end

  assign w_full = (r_level == LVL_W'(DEPTH));
  assign w_pop  = rec_valid & rec_ready;
  assign w_push = w_capture & (~w_full | w_pop);
  assign w_drop = w_capture & w_full & ~w_pop;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ts       <= '0;
      r_first    <= 1'b1;
      r_prev_p   <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_drop_cnt <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_ts     <= r_ts + TS_W'(1);
      r_first  <= ~cap_en;
      r_prev_p <= w_payload;
      if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
      end
    end
  end

  // When full with a simultaneous pop, the write lands in the slot being read out.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {r_ts, w_payload};
  end

  assign rec_data  = r_mem[r_rd_ptr];
  assign rec_valid = (r_level != '0);
  assign level     = r_level;
  assign drop_cnt  = r_drop_cnt;
  assign overflow  = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_lane_trace_capture.sv
// ============================================================================
// tb_lane_trace_capture: randomized scoreboard bench for lane_trace_capture.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_lane_trace_capture;

  localparam int LANS  = 4;
  localparam int BYTES = 2;
  localparam int DEPTH = 16;
  localparam int TS_W  = 64;
  localparam int P_W   = 2*LANS*(9*BYTES+1);
  localparam int REC_W = TS_W + P_W;
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    cap_en = 1'b0;
  logic [1:0]              mode = 2'd0;
  logic [LANS*BYTES*8-1:0] rdat = '0;
  logic [LANS*BYTES-1:0]   rdatk = '0;
  logic [LANS-1:0]         rdatv = '0;
  logic [LANS*BYTES*8-1:0] tdat = '0;
  logic [LANS*BYTES-1:0]   tdatk = '0;
  logic [LANS-1:0]         tdatv = '0;
  logic [REC_W-1:0]        rec_data;
  logic                    rec_valid;
  logic                    rec_ready = 1'b0;
  logic [LVL_W-1:0]        level;
  logic [15:0]             drop_cnt;
  logic                    overflow;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  lane_trace_capture #(
    .LANS(LANS), .BYTES(BYTES), .DEPTH(DEPTH), .TS_W(TS_W), .MODE_RST(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cap_en(cap_en), .mode(mode),
    .rdat(rdat), .rdatk(rdatk), .rdatv(rdatv),
    .tdat(tdat), .tdatk(tdatk), .tdatv(tdatv),
    .rec_data(rec_data), .rec_valid(rec_valid), .rec_ready(rec_ready),
    .level(level), .drop_cnt(drop_cnt), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Reference model: FIFO occupancy as a count, expected records in a queue.
  logic [REC_W-1:0] exp_q[$];
  logic [TS_W-1:0]  m_ts = '0;
  bit               m_first = 1'b1;
  logic [P_W-1:0]   m_prev = '0;
  int               m_level = 0;
  int               m_drop = 0;
  bit               m_ovf = 1'b0;

  always @(posedge clk) begin
    logic [P_W-1:0] p;
    bit cap;
    bit pop;
    if (!rst_n) begin
      exp_q.delete();
      m_ts = '0;
      m_first = 1'b1;
      m_level = 0;
      m_drop = 0;
      m_ovf = 1'b0;
    end else begin
      p = {rdatv, rdatk, rdat, tdatv, tdatk, tdat};
      cap = 1'b0;
      if (cap_en) begin
        if (mode == 2'd1)      cap = (rdatv != 0) || (tdatv != 0);
        else if (mode == 2'd2) cap = m_first || (p != m_prev);
        else                   cap = 1'b1;
      end
      pop = (m_level > 0) && rec_ready;
      if (cap) begin
        if (m_level < DEPTH || pop) begin
          exp_q.push_back({m_ts, p});
          m_level++;
        end else begin
          if (m_drop < 65535) m_drop++;
          m_ovf = 1'b1;
        end
      end
      if (pop) m_level--;
      m_first = !cap_en;
      m_prev = p;
      m_ts = m_ts + 1;
    end
  end

  // Monitor: status every cycle, record contents on each handshake.
  always @(negedge clk) begin
    logic [REC_W-1:0] exp;
    if (mon_en) begin
      checks++;
      if (rec_valid !== (m_level != 0)) begin
        errors++;
        $display("FAIL rec_valid: got %b expected %b at %0t", rec_valid, (m_level != 0), $time);
      end
      checks++;
      if (level !== LVL_W'(m_level)) begin
        errors++;
        $display("FAIL level: got %0d expected %0d at %0t", level, m_level, $time);
      end
      checks++;
      if (drop_cnt !== 16'(m_drop)) begin
        errors++;
        $display("FAIL drop_cnt: got %0d expected %0d at %0t", drop_cnt, m_drop, $time);
      end
      checks++;
      if (overflow !== m_ovf) begin
        errors++;
        $display("FAIL overflow: got %b expected %b at %0t", overflow, m_ovf, $time);
      end
      if (rec_valid === 1'b1 && rec_ready === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL record: got unexpected record ts=%0d expected none at %0t",
                   rec_data[REC_W-1 -: TS_W], $time);
        end else begin
          exp = exp_q.pop_front();
          if (rec_data !== exp) begin
            errors++;
            $display("FAIL record: got ts=%0d p=%0h expected ts=%0d p=%0h at %0t",
                     rec_data[REC_W-1 -: TS_W], rec_data[P_W-1:0],
                     exp[REC_W-1 -: TS_W], exp[P_W-1:0], $time);
          end
        end
      end
    end
  end

  task automatic new_payload(input bit sparse_v);
    rdat  = {$urandom(), $urandom()};
    tdat  = {$urandom(), $urandom()};
    rdatk = 8'($urandom());
    tdatk = 8'($urandom());
    if (sparse_v) begin
      rdatv = ($urandom_range(7) == 0) ? 4'b0010 : 4'b0000;
      tdatv = 4'b0000;
    end else begin
      rdatv = 4'($urandom());
      tdatv = 4'($urandom());
    end
  endtask

  task automatic step(input bit en, input logic [1:0] md, input bit rdy,
                      input int chg_pct, input bit sparse_v);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cap_en = en;
    mode = md;
    rec_ready = rdy;
    if (int'($urandom_range(99)) < chg_pct) new_payload(sparse_v);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      cap_en = 1'($urandom());
      rec_ready = 1'($urandom());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    do_reset(2);
    mon_en = 1'b1;
    repeat (5)  step(1'b1, 2'd0, 1'b1, 100, 1'b0);
    repeat (30) step(1'b1, 2'd1, 1'($urandom_range(1)), 100, 1'b1);
    repeat (40) step(($urandom_range(9) != 0), 2'd2, 1'($urandom_range(1)), 10, 1'b0);
    do_reset(1);
    repeat (20) step(1'b1, 2'd0, 1'b0, 100, 1'b0);
    repeat (20) step(1'b1, 2'd0, 1'b1, 100, 1'b0);
    repeat (16) step(1'b1, 2'd0, 1'b0, 100, 1'b0);
    repeat (10) step(1'b1, 2'd0, 1'b1, 100, 1'b0);
    repeat (30) step(1'($urandom()), 2'd3, 1'($urandom()), 50, 1'b0);
    do_reset(1);
    repeat (12) step(1'b1, 2'd0, 1'b0, 100, 1'b0);
    do_reset(1);
    repeat (300) step(($urandom_range(7) != 0), 2'($urandom()), ($urandom_range(3) != 0),
                      40, 1'($urandom()));
    repeat (20) step(1'b0, 2'd0, 1'b1, 0, 1'b0);
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d undelivered records expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
